conv_controller_param: RTL and testbench

Parametrised convolution sequencer for a KSIZE x KSIZE kernel. It first fills the sample window, then alternates between convolving and streaming one new sample per request. It also loads KSIZE coefficient rows on demand. It sits between the host load interface and the sample/coefficient register files and MAC datapath. It adds a protocol-error flag and a per-row stream counter.

---
 rtl/conv_controller_param.sv | 153 +++++++++++++++
 tb/tb_conv_controller_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_controller_param.sv
`default_nettype none
// ============================================================================
// Module      : conv_controller_param
// Description : Convolution sequencer for a KSIZE x KSIZE kernel. Fills the
//               sample window, alternates convolve/stream, loads coefficient
//               rows, tracks a sticky protocol error and a stream counter.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_controller_param #(
   parameter  int KSIZE = 3,
   parameter  int CNT_W = 8,
   localparam int SEL_W = (KSIZE > 1) ? $clog2(KSIZE) : 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             sample_load_en,
   input  logic             new_row,
   input  logic             coeff_load_en,
   input  logic             clear_err,
   output logic             modwait,
   output logic             sample_stream,
   output logic             sample_shift,
   output logic             convolve_en,
   output logic             coeff_ld,
   output logic [SEL_W-1:0] coeff_sel,
   output logic [CNT_W-1:0] stream_count,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FILL_WAIT  = 3'd1,
      S_FILL_LOAD  = 3'd2,
      S_CONVOLVE   = 3'd3,
      S_STREAM     = 3'd4,
      S_COEFF_LOAD = 3'd5
   } state_t;

   localparam logic [SEL_W-1:0] ROW_LAST = SEL_W'(KSIZE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   row_q, row_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               cnt_clr;
   logic               viol;

   // State, row counter, stream counter and error flag registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state and row-counter logic; cnt_clr marks entry into a fresh fill
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_clr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (coeff_load_en) begin
               row_d   = '0;
               state_d = S_COEFF_LOAD;
            end else if (sample_load_en) begin
               row_d   = '0;
               state_d = S_FILL_LOAD;
               cnt_clr = 1'b1;
            end
         end
         S_FILL_LOAD: begin
            if (row_q == ROW_LAST) begin
               state_d = S_CONVOLVE;
            end else begin
               row_d   = row_q + SEL_W'(1);
               state_d = S_FILL_WAIT;
            end
         end
         S_FILL_WAIT: begin
            if (sample_load_en) state_d = S_FILL_LOAD;
         end
         S_CONVOLVE: begin
            if (new_row && sample_load_en) begin
               state_d = S_IDLE;
            end else if (coeff_load_en) begin
               row_d   = '0;
               state_d = S_COEFF_LOAD;
            end else if (new_row) begin
               row_d   = '0;
               state_d = S_FILL_LOAD;
               cnt_clr = 1'b1;
            end else if (sample_load_en) begin
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            state_d = S_CONVOLVE;
         end
         S_COEFF_LOAD: begin
            if (row_q == ROW_LAST) begin
               state_d = S_IDLE;
            end else begin
               row_d = row_q + SEL_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            row_d   = '0;
         end
      endcase
   end

   // Saturating stream counter and sticky error (a new violation beats clear)
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if ((state_q == S_STREAM) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      viol = (coeff_load_en && ((state_q == S_FILL_WAIT) || (state_q == S_FILL_LOAD) ||
                                (state_q == S_STREAM)    || (state_q == S_COEFF_LOAD)))
          || (new_row       && ((state_q == S_FILL_WAIT) || (state_q == S_FILL_LOAD) ||
                                (state_q == S_STREAM)));
      if (viol)           err_d = 1'b1;
      else if (clear_err) err_d = 1'b0;
      else                err_d = err_q;
   end

   // Moore output decode from the registered state
   always_comb begin
      modwait       = (state_q == S_FILL_LOAD) || (state_q == S_STREAM) ||
                      (state_q == S_COEFF_LOAD);
      sample_shift  = (state_q == S_FILL_LOAD) || (state_q == S_STREAM);
      convolve_en   = (state_q == S_CONVOLVE);
      sample_stream = (state_q == S_CONVOLVE);
      coeff_ld      = (state_q == S_COEFF_LOAD);
      coeff_sel     = (state_q == S_COEFF_LOAD) ? row_q : '0;
      stream_count  = cnt_q;
      err           = err_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_controller_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_controller_param
// Description : Self-checking bench for conv_controller_param. Three builds
//               (K=3/W=8, K=5/W=8, K=3/W=2) share the same stimulus and are
//               compared against an abstract behavioural model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_controller_param;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic sl = 1'b0, nr = 1'b0, cl = 1'b0, ce = 1'b0;

   logic       mw[3], ss[3], sh[3], cv[3], ld[3], er[3];
   logic [1:0] sel3, selc;
   logic [2:0] sel5;
   logic [7:0] cnt3, cnt5;
   logic [1:0] cntc;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   conv_controller_param #(.KSIZE(3), .CNT_W(8)) u_k3 (
      .clk(clk), .n_rst(n_rst), .sample_load_en(sl), .new_row(nr),
      .coeff_load_en(cl), .clear_err(ce), .modwait(mw[0]), .sample_stream(ss[0]),
      .sample_shift(sh[0]), .convolve_en(cv[0]), .coeff_ld(ld[0]),
      .coeff_sel(sel3), .stream_count(cnt3), .err(er[0]));

   conv_controller_param #(.KSIZE(5), .CNT_W(8)) u_k5 (
      .clk(clk), .n_rst(n_rst), .sample_load_en(sl), .new_row(nr),
      .coeff_load_en(cl), .clear_err(ce), .modwait(mw[1]), .sample_stream(ss[1]),
      .sample_shift(sh[1]), .convolve_en(cv[1]), .coeff_ld(ld[1]),
      .coeff_sel(sel5), .stream_count(cnt5), .err(er[1]));

   conv_controller_param #(.KSIZE(3), .CNT_W(2)) u_c2 (
      .clk(clk), .n_rst(n_rst), .sample_load_en(sl), .new_row(nr),
      .coeff_load_en(cl), .clear_err(ce), .modwait(mw[2]), .sample_stream(ss[2]),
      .sample_shift(sh[2]), .convolve_en(cv[2]), .coeff_ld(ld[2]),
      .coeff_sel(selc), .stream_count(cntc), .err(er[2]));

   // Abstract model: what the block is doing, not how it encodes it
   typedef struct {
      int k;           // kernel rows
      int cmax;        // stream counter ceiling
      bit filling;     // window refill in progress
      int rows;        // rows shifted so far during the refill
      bit shift_now;   // a sample row is being shifted this cycle
      bit ready;       // window valid, convolving
      int coeff_left;  // coefficient rows still to write (incl. current)
      int cnt;
      bit err;
   } m_t;

   m_t m[3];

   function automatic m_t m_reset(int k, int cmax);
      m_t s;
      s.k = k; s.cmax = cmax; s.filling = 0; s.rows = 0; s.shift_now = 0;
      s.ready = 0; s.coeff_left = 0; s.cnt = 0; s.err = 0;
      return s;
   endfunction

   function automatic m_t step(m_t s, bit a_sl, bit a_nr, bit a_cl, bit a_ce);
      m_t  n = s;
      bit  in_stream = s.shift_now && !s.filling;
      bit  busy = s.filling || s.shift_now || (s.coeff_left > 0);
      bit  viol = (a_cl && busy) || (a_nr && (s.filling || s.shift_now));
      n.err = viol ? 1'b1 : (a_ce ? 1'b0 : s.err);
      if (in_stream && s.cnt < s.cmax) n.cnt = s.cnt + 1;
      if (s.coeff_left > 0) begin
         n.coeff_left = s.coeff_left - 1;
      end else if (s.filling) begin
         if (s.shift_now) begin
            n.shift_now = 0;
            if (s.rows == s.k) begin n.filling = 0; n.ready = 1; end
         end else if (a_sl) begin
            n.shift_now = 1; n.rows = s.rows + 1;
         end
      end else if (in_stream) begin
         n.shift_now = 0; n.ready = 1;
      end else if (s.ready) begin
         if (a_nr && a_sl) n.ready = 0;
         else if (a_cl) begin n.ready = 0; n.coeff_left = s.k; end
         else if (a_nr) begin
            n.ready = 0; n.filling = 1; n.shift_now = 1; n.rows = 1; n.cnt = 0;
         end else if (a_sl) begin n.ready = 0; n.shift_now = 1; end
      end else begin
         if (a_cl) n.coeff_left = s.k;
         else if (a_sl) begin
            n.filling = 1; n.shift_now = 1; n.rows = 1; n.cnt = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] pack(bit a_mw, bit a_ss, bit a_sh, bit a_cv,
                                        bit a_ld, int a_sel, int a_cnt, bit a_er);
      logic [31:0] v = '0;
      v[29] = a_mw; v[28] = a_ss; v[27] = a_sh; v[26] = a_cv; v[25] = a_ld;
      v[24] = a_er; v[15:8] = a_sel[7:0]; v[7:0] = a_cnt[7:0];
      return v;
   endfunction

   function automatic logic [31:0] expv(m_t s);
      bit c = s.coeff_left > 0;
      return pack(s.shift_now || c, s.ready, s.shift_now, s.ready, c,
                  c ? (s.k - s.coeff_left) : 0, s.cnt, s.err);
   endfunction

   function automatic logic [31:0] actv(int i);
      case (i)
         0:       return pack(mw[0], ss[0], sh[0], cv[0], ld[0], int'(sel3), int'(cnt3), er[0]);
         1:       return pack(mw[1], ss[1], sh[1], cv[1], ld[1], int'(sel5), int'(cnt5), er[1]);
         default: return pack(mw[2], ss[2], sh[2], cv[2], ld[2], int'(selc), int'(cntc), er[2]);
      endcase
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_all(string tag);
      for (int i = 0; i < 3; i++) check($sformatf("%s dut%0d", tag, i), actv(i), expv(m[i]));
   endtask

   task automatic models_reset();
      m[0] = m_reset(3, 255);
      m[1] = m_reset(5, 255);
      m[2] = m_reset(3, 3);
   endtask

   // Apply one cycle of inputs, advance the model at the edge, compare just after
   task automatic cyc(bit a_sl, bit a_nr, bit a_cl, bit a_ce, string tag);
      sl = a_sl; nr = a_nr; cl = a_cl; ce = a_ce;
      @(posedge clk);
      for (int i = 0; i < 3; i++) m[i] = step(m[i], a_sl, a_nr, a_cl, a_ce);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop before any edge
   task automatic do_reset(string tag);
      sl = 0; nr = 0; cl = 0; ce = 0;
      #2 n_rst = 1'b0;
      #1;
      models_reset();
      for (int i = 0; i < 3; i++) check($sformatf("%s async dut%0d", tag, i), actv(i), 32'h0);
      @(posedge clk);
      @(negedge clk) n_rst = 1'b1;
      @(posedge clk);
      #1;
      check_all({tag, " release"});
   endtask

   typedef struct {
      bit sl, nr, cl, ce;
      bit mw, ss, sh, cv, ld;
      int sel, cnt;
      bit er;
   } vec_t;

   vec_t tbl[25];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      // Expected outputs of the K=3/W=8 build, one row per cycle from reset
      tbl[0]  = '{1,0,0,0, 1,0,1,0,0, 0,0,0};
      tbl[1]  = '{0,0,0,0, 0,0,0,0,0, 0,0,0};
      tbl[2]  = '{0,0,0,0, 0,0,0,0,0, 0,0,0};
      tbl[3]  = '{1,0,0,0, 1,0,1,0,0, 0,0,0};
      tbl[4]  = '{0,0,0,0, 0,0,0,0,0, 0,0,0};
      tbl[5]  = '{0,0,0,0, 0,0,0,0,0, 0,0,0};
      tbl[6]  = '{1,0,0,0, 1,0,1,0,0, 0,0,0};
      tbl[7]  = '{0,0,0,0, 0,1,0,1,0, 0,0,0};
      tbl[8]  = '{0,0,0,0, 0,1,0,1,0, 0,0,0};
      tbl[9]  = '{1,0,0,0, 1,0,1,0,0, 0,0,0};
      tbl[10] = '{0,0,0,0, 0,1,0,1,0, 0,1,0};
      tbl[11] = '{1,0,0,0, 1,0,1,0,0, 0,1,0};
      tbl[12] = '{0,0,0,0, 0,1,0,1,0, 0,2,0};
      tbl[13] = '{0,0,1,0, 1,0,0,0,1, 0,2,0};
      tbl[14] = '{0,0,1,0, 1,0,0,0,1, 1,2,1};
      tbl[15] = '{0,0,0,0, 1,0,0,0,1, 2,2,1};
      tbl[16] = '{0,0,0,1, 0,0,0,0,0, 0,2,0};
      tbl[17] = '{1,0,0,0, 1,0,1,0,0, 0,0,0};
      tbl[18] = '{0,0,1,0, 0,0,0,0,0, 0,0,1};
      tbl[19] = '{1,1,0,1, 1,0,1,0,0, 0,0,1};
      tbl[20] = '{0,0,0,0, 0,0,0,0,0, 0,0,1};
      tbl[21] = '{1,0,0,0, 1,0,1,0,0, 0,0,1};
      tbl[22] = '{0,0,0,0, 0,1,0,1,0, 0,0,1};
      tbl[23] = '{1,1,0,0, 0,0,0,0,0, 0,0,1};
      tbl[24] = '{0,0,0,1, 0,0,0,0,0, 0,0,0};

      // Power-on reset
      models_reset();
      #2;
      for (int i = 0; i < 3; i++) check($sformatf("por dut%0d", i), actv(i), 32'h0);
      @(negedge clk) n_rst = 1'b1;
      @(posedge clk);
      #1;
      check_all("por release");

      // Table-driven directed vectors
      for (int i = 0; i < 25; i++) begin
         cyc(tbl[i].sl, tbl[i].nr, tbl[i].cl, tbl[i].ce, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d k3", i), actv(0),
               pack(tbl[i].mw, tbl[i].ss, tbl[i].sh, tbl[i].cv, tbl[i].ld,
                    tbl[i].sel, tbl[i].cnt, tbl[i].er));
      end

      // coeff_load_en beats new_row in CONVOLVE
      do_reset("prio");
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, "prio fill");
         cyc(0, 0, 0, 0, "prio gap");
      end
      cyc(0, 1, 1, 0, "prio cl+nr");
      check("prio k3 coeff", actv(0), pack(1, 0, 0, 0, 1, 0, 0, 0));

      // K=5 coefficient load walks rows 0..4 on consecutive cycles
      do_reset("k5coef");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "k5coef start");
      for (int r = 0; r < 5; r++) begin
         check($sformatf("k5coef row%0d", r), {31'h0, ld[1]} | ({24'h0, 5'h0, sel5} << 8),
               32'h1 | (r << 8));
         cyc(0, 0, 0, 0, "k5coef run");
      end
      check("k5coef done", {31'h0, ld[1]}, 32'h0);

      // Stream counter saturation in the 2-bit build
      do_reset("sat");
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, "sat fill");
         cyc(0, 0, 0, 0, "sat gap");
      end
      for (int s = 1; s <= 5; s++) begin
         cyc(1, 0, 0, 0, "sat stream");
         cyc(0, 0, 0, 0, "sat conv");
         check($sformatf("sat cnt2 after %0d", s), {30'h0, cntc}, (s > 3) ? 32'd3 : s);
      end
      check("sat cnt8 after 5", {24'h0, cnt3}, 32'd5);
      cyc(0, 1, 0, 0, "sat newrow");
      check("sat newrow clears", {24'h0, cnt3}, 32'd0);

      // Asynchronous reset during coefficient row 1 with err set
      do_reset("rstco");
      cyc(0, 0, 1, 0, "rstco row0");
      cyc(0, 0, 1, 0, "rstco row1 viol");
      check("rstco k3 row1 err", actv(0), pack(1, 0, 0, 0, 1, 1, 0, 1));
      do_reset("rstco");

      // Randomised traffic with occasional mid-run resets
      for (int c = 0; c < 3000; c++) begin
         if (c % 700 == 699) do_reset("rnd");
         cyc(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 12) == 0,
             ($urandom % 10) == 0, $sformatf("rnd%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
